// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the 00-59 s stopwatch: sync, debounce, run/pause/lap/clear FSM.
// Drives counter run-enable and clear, and muxes a frozen lap value to the display.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 2_500_000,
    parameter int DB_W      = $clog2(DB_CYCLES) + 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SS,
    input  logic       BTN_LC,
    input  logic [3:0] NUM_1S,
    input  logic [2:0] NUM_10S,
    output logic       SW_START,
    output logic       SW_CLR,
    output logic [3:0] DISP_1S,
    output logic [2:0] DISP_10S,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 0 is start/stop, bit 1 is lap/clear.
    logic [1:0]      btn;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_d;
    logic [1:0]      press;
    logic [DB_W-1:0] cnt [2];

    logic            ss;
    logic            lc;
    state_t          state;
    logic            sw_start;
    logic            sw_clr;
    logic [3:0]      lap_1s;
    logic [2:0]      lap_10s;

    assign btn = {BTN_LC, BTN_SS};

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level; start/stop wins a tie.
    assign press = stable & ~stable_d;
    assign ss    = press[0];
    assign lc    = press[1] & ~press[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            sw_start <= 1'b0;
            sw_clr   <= 1'b0;
            lap_1s   <= '0;
            lap_10s  <= '0;
        end else begin
            sw_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss) begin
                        state    <= RUN;
                        sw_start <= 1'b1;
                    end else if (lc) begin
                        sw_clr <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss) begin
                        state    <= PAUSE;
                        sw_start <= 1'b0;
                    end else if (lc) begin
                        state   <= LAP;
                        lap_1s  <= NUM_1S;
                        lap_10s <= NUM_10S;
                    end
                end
                LAP: begin
                    if (ss) begin
                        state    <= PAUSE;
                        sw_start <= 1'b0;
                    end else if (lc) begin
                        state <= RUN;
                    end
                end
                PAUSE: begin
                    if (ss) begin
                        state    <= RUN;
                        sw_start <= 1'b1;
                    end else if (lc) begin
                        state    <= IDLE;
                        sw_clr   <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sw_start <= 1'b0;
                end
            endcase
        end
    end

    assign SW_START = sw_start;
    assign SW_CLR   = sw_clr;
    assign STATE    = state;
    assign DISP_1S  = (state == LAP) ? lap_1s : NUM_1S;
    assign DISP_10S = (state == LAP) ? lap_10s : NUM_10S;

endmodule
